mem_bus_arbiter: RTL and testbench



---
 rtl/mem_bus_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the memory Wishbone bus.
// Master 0 is the BIU memory port, master 1 a secondary fetch engine.
// A master keeps the bus for as long as it holds cyc (bus lock).
// A watchdog aborts a transfer when the slave never acknowledges it.
module mem_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int DATA_W         = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                m0_cyc_i,
  input  logic                m0_stb_i,
  input  logic                m0_we_i,
  input  logic [31:0]         m0_adr_i,
  input  logic [DATA_W-1:0]   m0_dat_i,
  input  logic [DATA_W/8-1:0] m0_sel_i,
  output logic [DATA_W-1:0]   m0_dat_o,
  output logic                m0_ack_o,
  output logic                m0_err_o,
  input  logic                m1_cyc_i,
  input  logic                m1_stb_i,
  input  logic                m1_we_i,
  input  logic [31:0]         m1_adr_i,
  input  logic [DATA_W-1:0]   m1_dat_i,
  input  logic [DATA_W/8-1:0] m1_sel_i,
  output logic [DATA_W-1:0]   m1_dat_o,
  output logic                m1_ack_o,
  output logic                m1_err_o,
  output logic                s_cyc_o,
  output logic                s_stb_o,
  output logic                s_we_o,
  output logic [31:0]         s_adr_o,
  output logic [DATA_W-1:0]   s_dat_o,
  output logic [DATA_W/8-1:0] s_sel_o,
  input  logic [DATA_W-1:0]   s_dat_i,
  input  logic                s_ack_i,
  output logic [1:0]          gnt_o
);

  // A zero timeout disables the watchdog; keep the counter at least one bit wide.
  localparam bit WDOG_EN = TIMEOUT_CYCLES > 0;
  localparam int CNT_W   = WDOG_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int LAST_ST = WDOG_EN ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_ST);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT0  = 2'd1,
    GNT1  = 2'd2,
    ABORT = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;   // 1: master 1 held the bus most recently
  logic [CNT_W-1:0] cnt_q, cnt_d;     // consecutive stalled strobe cycles

  logic req0, req1, granted, sel1, own_cyc, own_stb, stall;

  assign req0    = m0_cyc_i & m0_stb_i;
  assign req1    = m1_cyc_i & m1_stb_i;
  assign granted = (state_q == GNT0) || (state_q == GNT1);
  assign sel1    = (state_q == GNT1);
  assign own_cyc = sel1 ? m1_cyc_i : m0_cyc_i;
  assign own_stb = sel1 ? m1_stb_i : m0_stb_i;
  assign stall   = granted & own_stb & ~s_ack_i;

  // Slave-side mux: the granted master drives the bus, everything is 0 otherwise.
  assign s_cyc_o = granted & own_cyc;
  assign s_stb_o = granted & own_stb;
  assign s_we_o  = granted & (sel1 ? m1_we_i : m0_we_i);
  assign s_adr_o = granted ? (sel1 ? m1_adr_i : m0_adr_i) : '0;
  assign s_dat_o = granted ? (sel1 ? m1_dat_i : m0_dat_i) : '0;
  assign s_sel_o = granted ? (sel1 ? m1_sel_i : m0_sel_i) : '0;

  // Ack goes only to the owner; err names the master whose transfer was aborted.
  assign m0_ack_o = (state_q == GNT0) & s_ack_i;
  assign m1_ack_o = (state_q == GNT1) & s_ack_i;
  assign m0_err_o = (state_q == ABORT) & ~last_q;
  assign m1_err_o = (state_q == ABORT) & last_q;
  assign gnt_o    = {state_q == GNT1, state_q == GNT0};

  // Read data is broadcast, but forced to 0 while reset is held.
  assign m0_dat_o = rst_i ? s_dat_i : '0;
  assign m1_dat_o = rst_i ? s_dat_i : '0;

  // Next-state logic: round-robin arbitration, lock release and watchdog.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = '0;
    case (state_q)
      IDLE: begin
        if (req0 && req1) state_d = last_q ? GNT0 : GNT1;
        else if (req0)    state_d = GNT0;
        else if (req1)    state_d = GNT1;
      end
      GNT0, GNT1: begin
        if (!own_cyc) begin
          state_d = IDLE;
          last_d  = sel1;
        end else if (stall && WDOG_EN) begin
          // The ack check lives in stall, so an ack on the threshold cycle wins.
          if (cnt_q == CNT_LAST) begin
            state_d = ABORT;
            last_d  = sel1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; the arbiter state is all control, so all of it is reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios with literal
// expectations plus a randomized run compared against a behavioural model.
module tb_mem_bus_arbiter;
  localparam int TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i;
  logic        m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
  logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic [3:0]  s_sel_o;
  logic        s_ack_i;
  logic [1:0]  gnt_o;

  // Slave model: either acks every strobe at once, or follows ack_r.
  logic auto_ack, ack_r;
  assign s_ack_i = (auto_ack & s_stb_o) | ack_r;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(TO), .DATA_W(32)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .gnt_o(gnt_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic masters_off();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0;
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0;
  endtask

  // Behavioural model: who owns the bus, who is being aborted, who went last,
  // and how many consecutive unacknowledged strobe cycles the owner has seen.
  int owner    = -1;
  int abort_of = -1;
  int last_m   = 1;
  int stall_n  = 0;

  always @(negedge clk) begin : compare
    logic [12:0] ec, ac;
    logic [31:0] ea, ed, emd;
    logic        oc, os, r0, r1;
    ec  = '0;
    ea  = '0;
    ed  = '0;
    emd = rst_i ? s_dat_i : 32'h0;
    if (rst_i && owner == 0) begin
      ec = {m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, 2'b01, s_ack_i, 1'b0, 2'b00};
      ea = m0_adr_i;
      ed = m0_dat_i;
    end else if (rst_i && owner == 1) begin
      ec = {m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, 2'b10, 1'b0, s_ack_i, 2'b00};
      ea = m1_adr_i;
      ed = m1_dat_i;
    end else if (rst_i && abort_of >= 0) begin
      ec = {11'b0, abort_of == 0, abort_of == 1};
    end
    ac = {s_cyc_o, s_stb_o, s_we_o, s_sel_o, gnt_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o};
    chk("ctrl", 64'(ac), 64'(ec));
    chk("s_adr", 64'(s_adr_o), 64'(ea));
    chk("s_dat", 64'(s_dat_o), 64'(ed));
    chk("m0_dat", 64'(m0_dat_o), 64'(emd));
    chk("m1_dat", 64'(m1_dat_o), 64'(emd));
    // advance the model to what should hold after the coming rising edge
    if (!rst_i) begin
      owner = -1; abort_of = -1; last_m = 1; stall_n = 0;
    end else if (abort_of >= 0) begin
      last_m   = abort_of;
      abort_of = -1;
    end else if (owner >= 0) begin
      oc = (owner == 0) ? m0_cyc_i : m1_cyc_i;
      os = (owner == 0) ? m0_stb_i : m1_stb_i;
      if (!oc) begin
        last_m  = owner;
        owner   = -1;
        stall_n = 0;
      end else if (os && !s_ack_i) begin
        stall_n++;
        if (stall_n == TO) begin
          abort_of = owner;
          owner    = -1;
          stall_n  = 0;
        end
      end else begin
        stall_n = 0;
      end
    end else begin
      r0 = m0_cyc_i & m0_stb_i;
      r1 = m1_cyc_i & m1_stb_i;
      if (r0 && r1)  owner = 1 - last_m;
      else if (r0)   owner = 0;
      else if (r1)   owner = 1;
    end
  end

  logic [1:0] tie_exp [12] = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd2, 2'd2,
                               2'd0, 2'd1, 2'd1, 2'd0, 2'd2, 2'd2};

  initial begin
    logic a0, a1;
    rst_i = 1'b0; auto_ack = 1'b0; ack_r = 1'b0;
    masters_off();
    m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = 4'hF;
    m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = 4'hF;
    s_dat_i  = 32'hA5A5A5A5;

    // reset holds every output at 0 even with requests and ack present
    tick();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; ack_r = 1'b1;
    repeat (2) tick();
    chk("rst_gnt", 64'(gnt_o), 64'd0);
    chk("rst_stb", 64'(s_stb_o), 64'd0);
    chk("rst_ack", 64'(m0_ack_o), 64'd0);
    chk("rst_dat", 64'(m0_dat_o), 64'd0);
    ack_r = 1'b0;

    // tie: both request continuously, each drops cyc for one cycle after its ack
    rst_i = 1'b1; auto_ack = 1'b1;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk($sformatf("tie_gnt%0d", i), 64'(gnt_o), 64'(tie_exp[i]));
      a0 = m0_ack_o;
      a1 = m1_ack_o;
      tick();
      m0_cyc_i = !a0; m0_stb_i = !a0;
      m1_cyc_i = !a1; m1_stb_i = !a1;
    end
    masters_off(); auto_ack = 1'b0;
    repeat (3) tick();

    // single master read of 0x100, slave answers 0xDEADBEEF
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h0000_0100;
    @(negedge clk);
    chk("single_stb_idle", 64'(s_stb_o), 64'd0);
    tick();
    @(negedge clk);
    chk("single_stb", 64'(s_stb_o), 64'd1);
    chk("single_gnt", 64'(gnt_o), 64'd1);
    chk("single_adr", 64'(s_adr_o), 64'h100);
    tick();
    tick();
    ack_r = 1'b1; s_dat_i = 32'hDEADBEEF;
    @(negedge clk);
    chk("single_ack", 64'(m0_ack_o), 64'd1);
    chk("single_dat", 64'(m0_dat_o), 64'hDEADBEEF);
    chk("single_m1ack", 64'(m1_ack_o), 64'd0);
    chk("single_gnt2", 64'(gnt_o), 64'd1);
    tick();
    ack_r = 1'b0; masters_off();
    repeat (2) tick();

    // lock: m1 keeps cyc for 4 writes while m0 requests throughout
    auto_ack = 1'b1;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1; m1_adr_i = 32'h2000;
    tick();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("lock_gnt%0d", k), 64'(gnt_o), 64'd2);
      chk($sformatf("lock_ack%0d", k), 64'(m1_ack_o), 64'd1);
      chk($sformatf("lock_we%0d", k), 64'(s_we_o), 64'd1);
      tick();
      m1_adr_i = m1_adr_i + 32'd4;
      if (k == 4) begin
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0;
      end
    end
    @(negedge clk);
    chk("lock_drop_gnt", 64'(gnt_o), 64'd2);
    tick();
    @(negedge clk);
    chk("lock_idle", 64'(gnt_o), 64'd0);
    tick();
    @(negedge clk);
    chk("lock_m0_gnt", 64'(gnt_o), 64'd1);
    tick();
    masters_off(); auto_ack = 1'b0;
    repeat (2) tick();

    // timeout: slave never acks m0, m1 waits
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    tick();
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      chk($sformatf("to_noerr%0d", k), 64'(m0_err_o), 64'd0);
      chk($sformatf("to_gnt%0d", k), 64'(gnt_o), 64'd1);
      tick();
    end
    @(negedge clk);
    chk("to_err", 64'(m0_err_o), 64'd1);
    chk("to_m1err", 64'(m1_err_o), 64'd0);
    chk("to_cyc", 64'(s_cyc_o), 64'd0);
    tick();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    @(negedge clk);
    chk("to_idle", 64'(gnt_o), 64'd0);
    tick();
    @(negedge clk);
    chk("to_m1_gnt", 64'(gnt_o), 64'd2);
    tick();
    masters_off();
    repeat (2) tick();

    // ack on the 8th stall cycle beats the watchdog
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    repeat (TO - 1) tick();
    tick();
    ack_r = 1'b1;
    @(negedge clk);
    chk("thr_ack", 64'(m0_ack_o), 64'd1);
    chk("thr_noerr", 64'(m0_err_o), 64'd0);
    tick();
    ack_r = 1'b0;
    @(negedge clk);
    chk("thr_noerr2", 64'(m0_err_o), 64'd0);
    chk("thr_gnt", 64'(gnt_o), 64'd1);
    tick();
    masters_off();
    repeat (2) tick();

    // reset in the middle of an m1 transfer
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; s_dat_i = 32'h1234_5678;
    tick();
    @(negedge clk);
    chk("mid_stb", 64'(s_stb_o), 64'd1);
    chk("mid_gnt", 64'(gnt_o), 64'd2);
    @(posedge clk);
    #2 ack_r = 1'b1;
    #1 rst_i = 1'b0;
    #1;
    chk("mid_rst_stb", 64'(s_stb_o), 64'd0);
    chk("mid_rst_cyc", 64'(s_cyc_o), 64'd0);
    chk("mid_rst_gnt", 64'(gnt_o), 64'd0);
    chk("mid_rst_ack", 64'(m1_ack_o), 64'd0);
    chk("mid_rst_dat", 64'(m1_dat_o), 64'd0);
    ack_r = 1'b0;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    tick();
    rst_i = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", 64'(gnt_o), 64'd0);
    tick();
    @(negedge clk);
    chk("post_rst_m0", 64'(gnt_o), 64'd1);
    tick();
    masters_off();
    repeat (2) tick();

    // randomized traffic checked against the model every cycle
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 600; i++) begin
        tick();
        auto_ack = (ph == 0) || (ph == 1 && $urandom_range(0, 1) == 1);
        ack_r    = (ph == 1) ? ($urandom_range(0, 7) == 0) :
                   (ph == 2) ? ($urandom_range(0, 15) == 0) : 1'b0;
        if ($urandom_range(0, (ph == 3) ? 15 : 7) == 0) m0_cyc_i = ~m0_cyc_i;
        if ($urandom_range(0, (ph == 3) ? 15 : 7) == 0) m1_cyc_i = ~m1_cyc_i;
        m0_stb_i = m0_cyc_i & ((ph == 3) || ($urandom_range(0, 3) != 0));
        m1_stb_i = m1_cyc_i & ((ph == 3) || ($urandom_range(0, 3) != 0));
        m0_we_i  = 1'($urandom_range(0, 1));
        m1_we_i  = 1'($urandom_range(0, 1));
        m0_adr_i = $urandom; m0_dat_i = $urandom; m0_sel_i = 4'($urandom_range(0, 15));
        m1_adr_i = $urandom; m1_dat_i = $urandom; m1_sel_i = 4'($urandom_range(0, 15));
        s_dat_i  = $urandom;
        rst_i    = ($urandom_range(0, 399) != 0);
      end
    end
    tick();
    rst_i = 1'b1; masters_off(); auto_ack = 1'b0; ack_r = 1'b0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
